// File: rtl/sprite_line_renderer_if.sv
// Sprite ROM request/response bus.
// master: renderer side, drives the row request {sprite id, orientation, line index}.
// slave:  ROM side, returns the addressed row on rom_data exactly one cycle after the request.
interface sprite_line_renderer_if #(
    parameter int unsigned TILE_PX = 8
);
    localparam int unsigned LineW = $clog2(TILE_PX);

    logic [3:0]         rom_sprite_id;
    logic [1:0]         rom_orientation;
    logic [LineW-1:0]   rom_line_index;
    logic [TILE_PX-1:0] rom_data;

    modport master (
        output rom_sprite_id,
        output rom_orientation,
        output rom_line_index,
        input  rom_data
    );

    modport slave (
        input  rom_sprite_id,
        input  rom_orientation,
        input  rom_line_index,
        output rom_data
    );
endinterface

// File: rtl/sprite_line_renderer.sv
// Scanline sprite renderer for a 1-bit VGA stream.
// In each horizontal blank it scans the entity list for the next line, stores up to MAX_PER_LINE
// hits in slots and fetches one ROM row per slot. During the active region each pixel is looked
// up in the highest-priority slot covering the current tile column.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   entities           NUM_ENTITIES x {id[13:10], orientation[9:8], loc[7:0]}, index 0 first
//   counter_H/V        VGA pixel and line counters
//   rom                sprite ROM bus (master side)
//   colour             registered pixel, one cycle behind the counters
//   line_overflow      more hits than slots on the line being prepared/displayed
//   busy               high while scanning or fetching
module sprite_line_renderer #(
    parameter int unsigned NUM_ENTITIES = 9,
    parameter int unsigned MAX_PER_LINE = 4,
    parameter logic [NUM_ENTITIES-1:0] FLIP_MASK = 9'b110000000,
    parameter int unsigned TILE_PX = 8,
    parameter int unsigned UPSCALE = 5,
    parameter int unsigned SCREEN_TILES_H = 16,
    parameter int unsigned SCREEN_TILES_V = 12,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL = 525,
    parameter bit BG_COLOUR = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [14*NUM_ENTITIES-1:0] entities,
    input  logic [9:0]                 counter_H,
    input  logic [9:0]                 counter_V,
    sprite_line_renderer_if.master     rom,
    output logic                       colour,
    output logic                       line_overflow,
    output logic                       busy
);
    localparam int unsigned EW = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1;
    localparam int unsigned SW = $clog2(MAX_PER_LINE + 1);
    localparam int unsigned BW = $clog2(TILE_PX);
    localparam int unsigned CW = (SCREEN_TILES_H > 1) ? $clog2(SCREEN_TILES_H) : 1;

    localparam logic [9:0] TileL   = 10'(TILE_PX * UPSCALE);
    localparam logic [9:0] Up      = 10'(UPSCALE);
    localparam logic [9:0] TilesH  = 10'(SCREEN_TILES_H);
    localparam logic [9:0] NumLocs = 10'(SCREEN_TILES_H * SCREEN_TILES_V);
    localparam logic [9:0] HAct    = 10'(H_ACTIVE);
    localparam logic [9:0] VAct    = 10'(V_ACTIVE);
    localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);

    // Preparation must complete inside the horizontal blank.
    if (NUM_ENTITIES + MAX_PER_LINE + 1 >= 800 - H_ACTIVE) begin : g_prep_too_long
        $error("sprite_line_renderer: line preparation does not fit in horizontal blank");
    end

    typedef enum logic [1:0] {StIdle, StScan, StFetch} state_e;

    state_e                                 state_q, state_d;
    logic [EW-1:0]                          scan_idx_q, scan_idx_d;
    logic [SW-1:0]                          cnt_q, cnt_d;
    logic [SW-1:0]                          fetch_idx_q, fetch_idx_d;
    logic [MAX_PER_LINE-1:0]                slot_valid_q, slot_valid_d;
    logic [MAX_PER_LINE-1:0]                slot_flip_q, slot_flip_d;
    logic [MAX_PER_LINE-1:0][3:0]           slot_id_q, slot_id_d;
    logic [MAX_PER_LINE-1:0][1:0]           slot_or_q, slot_or_d;
    logic [MAX_PER_LINE-1:0][CW-1:0]        slot_col_q, slot_col_d;
    logic [MAX_PER_LINE-1:0][TILE_PX-1:0]   slot_buf_q, slot_buf_d;
    logic                                   overflow_q, overflow_d;
    logic                                   colour_q, colour_d;
    logic                                   busy_q, busy_d;

    // Geometry, all 10-bit so H = 799 and nv = 524 never truncate.
    logic [9:0]    nv, nv_row, h_tile;
    logic [BW-1:0] nv_line, h_bit;

    always_comb begin
        nv      = (counter_V == VLast) ? 10'd0 : counter_V + 10'd1;
        nv_row  = nv / TileL;
        nv_line = BW'((nv % TileL) / Up);
        h_tile  = counter_H / TileL;
        h_bit   = BW'((counter_H % TileL) / Up);
    end

    // Entity currently under scan.
    logic [13:0]   ent;
    logic          ent_flip, ent_hit;
    logic [9:0]    ent_loc;
    logic [CW-1:0] ent_col;

    always_comb begin
        ent      = '1;
        ent_flip = 1'b0;
        for (int i = 0; i < NUM_ENTITIES; i++) begin
            if (scan_idx_q == EW'(i)) begin
                ent      = entities[14*i +: 14];
                ent_flip = FLIP_MASK[i];
            end
        end
        ent_loc = {2'b00, ent[7:0]};
        ent_col = CW'(ent_loc % TilesH);
        ent_hit = (ent[13:10] != 4'hF) && (ent_loc < NumLocs) && ((ent_loc / TilesH) == nv_row);
    end

    always_comb begin
        state_d      = state_q;
        scan_idx_d   = scan_idx_q;
        cnt_d        = cnt_q;
        fetch_idx_d  = fetch_idx_q;
        slot_valid_d = slot_valid_q;
        slot_flip_d  = slot_flip_q;
        slot_id_d    = slot_id_q;
        slot_or_d    = slot_or_q;
        slot_col_d   = slot_col_q;
        slot_buf_d   = slot_buf_q;
        overflow_d   = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (counter_H == HAct) begin
                    slot_valid_d = '0;
                    overflow_d   = 1'b0;
                    scan_idx_d   = '0;
                    cnt_d        = '0;
                    if (nv < VAct) state_d = StScan;
                end
            end
            StScan: begin
                if (ent_hit) begin
                    if (cnt_q == SW'(MAX_PER_LINE)) begin
                        overflow_d = 1'b1;
                    end else begin
                        for (int s = 0; s < MAX_PER_LINE; s++) begin
                            if (cnt_q == SW'(s)) begin
                                slot_valid_d[s] = 1'b1;
                                slot_id_d[s]    = ent[13:10];
                                slot_or_d[s]    = ent[9:8];
                                slot_col_d[s]   = ent_col;
                                slot_flip_d[s]  = ent_flip;
                            end
                        end
                        cnt_d = cnt_q + SW'(1);
                    end
                end
                if (scan_idx_q == EW'(NUM_ENTITIES - 1)) begin
                    fetch_idx_d = '0;
                    state_d     = (cnt_d == '0) ? StIdle : StFetch;
                end else begin
                    scan_idx_d = scan_idx_q + EW'(1);
                end
            end
            StFetch: begin
                // Data for the request issued last cycle lands in the previous slot.
                for (int s = 0; s < MAX_PER_LINE; s++) begin
                    if (fetch_idx_q == SW'(s + 1)) slot_buf_d[s] = rom.rom_data;
                end
                if (fetch_idx_q == cnt_q) begin
                    state_d = StIdle;
                end else begin
                    fetch_idx_d = fetch_idx_q + SW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // ROM request for the slot addressed by fetch_idx_q; zero whenever no request is issued.
    always_comb begin
        rom.rom_sprite_id   = '0;
        rom.rom_orientation = '0;
        rom.rom_line_index  = '0;
        if (state_q == StFetch) begin
            for (int s = 0; s < MAX_PER_LINE; s++) begin
                if (fetch_idx_q == SW'(s) && slot_valid_q[s]) begin
                    rom.rom_sprite_id   = slot_id_q[s];
                    rom.rom_orientation = slot_or_q[s];
                    rom.rom_line_index  = nv_line;
                end
            end
        end
    end

    // Pixel lookup; iterating downward lets the lowest covering slot win.
    logic [BW-1:0] pix_idx;

    always_comb begin
        colour_d = 1'b0;
        pix_idx  = h_bit;
        if (counter_H < HAct && counter_V < VAct) begin
            colour_d = BG_COLOUR;
            for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
                if (slot_valid_q[s] && (10'(slot_col_q[s]) == h_tile)) begin
                    pix_idx  = (slot_flip_q[s] && slot_or_q[s][0]) ? BW'(TILE_PX - 1) - h_bit
                                                                   : h_bit;
                    colour_d = slot_buf_q[s][pix_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            scan_idx_q   <= '0;
            cnt_q        <= '0;
            fetch_idx_q  <= '0;
            slot_valid_q <= '0;
            slot_flip_q  <= '0;
            slot_id_q    <= '0;
            slot_or_q    <= '0;
            slot_col_q   <= '0;
            slot_buf_q   <= '0;
            overflow_q   <= 1'b0;
            colour_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_idx_q   <= scan_idx_d;
            cnt_q        <= cnt_d;
            fetch_idx_q  <= fetch_idx_d;
            slot_valid_q <= slot_valid_d;
            slot_flip_q  <= slot_flip_d;
            slot_id_q    <= slot_id_d;
            slot_or_q    <= slot_or_d;
            slot_col_q   <= slot_col_d;
            slot_buf_q   <= slot_buf_d;
            overflow_q   <= overflow_d;
            colour_q     <= colour_d;
            busy_q       <= busy_d;
        end
    end

    assign colour        = colour_q;
    assign line_overflow = overflow_q;
    assign busy          = busy_q;
endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Parametrised successor to the frame buffer controller. It renders up to `NUM_ENTITIES` tile-aligned sprites into a 1-bit VGA pixel stream. During each horizontal blank it scans the entity list for the next line and fetches the needed sprite rows from the sprite ROM into per-slot line buffers. During the active region it outputs each pixel by priority lookup into those buffers. It sits between the game control logic (entity bus), the sprite ROM, and the VGA output stage.

## Interface

**Parameters**
- `NUM_ENTITIES`, 9: number of entity channels.
- `MAX_PER_LINE`, 4: line-buffer slots (sprites per scanline).
- `FLIP_MASK`, 9'b110000000: bit i=1 means entity i supports horizontal mirroring.
- `TILE_PX`, 8: sprite width/height in source pixels.
- `UPSCALE`, 5: screen pixels per source pixel.
- `SCREEN_TILES_H`, 16: tile columns.
- `SCREEN_TILES_V`, 12: tile rows.
- `H_ACTIVE`, 640: active horizontal pixels.
- `V_ACTIVE`, 480: active lines.
- `V_TOTAL`, 525: total lines per frame.
- `BG_COLOUR`, 1: colour of active pixels not covered by any sprite.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `entities` in 14*NUM_ENTITIES: entity i occupies [14i+13:14i] = {ID[13:10], orientation[9:8], tile location[7:0]}. ID 4'hF = unused. Index 0 has highest priority.
- `counter_H` in 10: horizontal pixel counter, 0..799.
- `counter_V` in 10: vertical line counter, 0..V_TOTAL-1.
- `rom_sprite_id` out 4: ROM request sprite ID.
- `rom_orientation` out 2: ROM request orientation.
- `rom_line_index` out 3: ROM request row within the sprite.
- `rom_data` in 8: ROM row data, valid exactly 1 cycle after the request.
- `colour` out 1: pixel output, 0 = black, 1 = white.
- `line_overflow` out 1: set when the current line had more hits than `MAX_PER_LINE`.
- `busy` out 1: high in SCAN or FETCH.

## Operation

**Geometry**
- Tile pixel length is L = TILE_PX*UPSCALE (40).
- Location decodes as col = loc % SCREEN_TILES_H and row = loc / SCREEN_TILES_H.
- Any loc ≥ SCREEN_TILES_H*SCREEN_TILES_V (192) is off-screen and never hits.
- Target line: nv = counter_V+1, wrapping from V_TOTAL-1 to 0.
- Line index for the target line is (nv % L)/UPSCALE.

**FSM states:** IDLE, SCAN, FETCH.
- IDLE → SCAN when counter_H == H_ACTIVE and nv < V_ACTIVE. On entry, all slots are invalidated and `line_overflow` is cleared.
- If counter_H == H_ACTIVE and nv ≥ V_ACTIVE, the block stays in IDLE, invalidates the slots, and clears `line_overflow`.
- SCAN examines one entity per cycle, index 0 → NUM_ENTITIES-1.
  - Hit condition: ID ≠ 4'hF, loc on-screen, and row == nv / L.
  - A hit with a free slot is stored in the next slot in index order: {ID, orientation, col, flip-enable}.
  - A hit with all slots full sets `line_overflow`; that entity is dropped.
- After the last entity:
  - zero hits → IDLE;
  - otherwise → FETCH.
- FETCH issues one ROM request per valid slot per cycle, in slot order, driving {ID, orientation, line index}. The returned `rom_data` is captured into that slot's 8-bit buffer on the following cycle. The block returns to IDLE on the cycle after the last capture.
- ROM request outputs hold 0 outside FETCH.

**Render**
- Render runs when counter_H < H_ACTIVE and counter_V < V_ACTIVE:
  - Find the lowest-numbered valid slot with col == counter_H / L.
  - Bit index b = (counter_H % L)/UPSCALE.
  - If the slot's flip-enable is set and orientation[0] == 1, use b' = 7 - b.
  - colour = buffer[b or b'].
  - No covering slot → BG_COLOUR.
- Outside the active region, colour = 0.
- Sprites are opaque: a 0 bit draws black over lower-priority sprites.

**Width rules**
- All divisions and moduli are by constants.
- Intermediate values are 10-bit and must not truncate at counter_H = 799 or nv = 524.

## Timing

- Reset values: FSM IDLE, all slots invalid, `colour` = 0, `line_overflow` = 0, `busy` = 0, ROM outputs 0.
- `colour` is registered: the value for pixel (H, V) appears the cycle after the counters show (H, V).
- Worst-case preparation is NUM_ENTITIES + MAX_PER_LINE + 1 cycles (14 at defaults), starting at H_ACTIVE. It must finish before the counter wraps; this requires NUM_ENTITIES + MAX_PER_LINE + 1 < 800 - H_ACTIVE, checked by elaboration-time assertion.
- Entity inputs are sampled during SCAN only. Changes during the active region take effect on the next line.
- `line_overflow` stays valid from the end of SCAN through the displayed line, until the next IDLE→SCAN.
- Reset asserted in SCAN or FETCH aborts immediately. After release the block waits for the next counter_H == H_ACTIVE; the line in progress renders as background.

## Test plan

- **Reset**: assert `reset` mid-FETCH → next cycle `colour` = 0, `busy` = 0, `line_overflow` = 0. The following line renders all BG (1) where no line was prepared.
- **Single sprite**: entity 0 = {ID 2, orient 0, loc 0x11}; the ROM model returns 8'b10100101 for ID 2 at every line index. Lines 40..79, H 40..79 → colour pattern per 5-pixel group 1,0,1,0,0,1,0,1. Elsewhere in the active region → 1.
- **Priority**: entities 0 and 3 both at loc 0x11, ROM rows 8'h00 and 8'hFF → pixels in that tile read 0 (entity 0 wins).
- **Overflow**: 5 entities on row 1 at cols 0..4 with MAX_PER_LINE = 4 → `line_overflow` = 1 on lines 40..79, col 4 renders BG, and exactly 4 ROM requests are issued per line.
- **Unused / off-screen**: ID 4'hF at loc 0x11, plus ID 1 at loc 200 → no ROM requests, all active pixels = 1.
- **Flip**: entity 8 (FLIP_MASK set), orientation 2'b01, ROM row 8'b00000001 → only H 75..79 of its tile are white. The same stimulus on entity 0 → only H 40..44 are white.
